// File: rtl/uvmt_cv32e40x_exception_sequencer_if.sv
// ============================================================================
// Module   : uvmt_cv32e40x_exception_sequencer_if
// Brief    : Pipeline handshake, exception flag and result bundle for the
//            exception sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uvmt_cv32e40x_exception_sequencer_if #(
  parameter int CAUSE_W = 11,
  parameter int COUNT_W = 16
);
  logic               ifid_hs_i;
  logic               idex_hs_i;
  logic               exwb_hs_i;
  logic               wb_retire_i;
  logic               flush_i;
  logic               if_pma_fault_i;
  logic               if_buserr_i;
  logic               id_illegal_i;
  logic               id_ebreak_i;
  logic               id_ecall_i;
  logic               ex_ld_misalign_i;
  logic               ex_st_misalign_i;
  logic               dut_exc_valid_i;
  logic [CAUSE_W-1:0] dut_exc_cause_i;
  logic               exc_valid_o;
  logic [CAUSE_W-1:0] exc_cause_o;
  logic [6:0]         exc_flags_o;
  logic               mismatch_o;
  logic [COUNT_W-1:0] exc_count_o;

  // Master drives pipeline events; slave is the sequencer
  modport master (
    output ifid_hs_i, idex_hs_i, exwb_hs_i, wb_retire_i, flush_i,
    output if_pma_fault_i, if_buserr_i, id_illegal_i, id_ebreak_i, id_ecall_i,
    output ex_ld_misalign_i, ex_st_misalign_i, dut_exc_valid_i, dut_exc_cause_i,
    input  exc_valid_o, exc_cause_o, exc_flags_o, mismatch_o, exc_count_o
  );

  modport slave (
    input  ifid_hs_i, idex_hs_i, exwb_hs_i, wb_retire_i, flush_i,
    input  if_pma_fault_i, if_buserr_i, id_illegal_i, id_ebreak_i, id_ecall_i,
    input  ex_ld_misalign_i, ex_st_misalign_i, dut_exc_valid_i, dut_exc_cause_i,
    output exc_valid_o, exc_cause_o, exc_flags_o, mismatch_o, exc_count_o
  );
endinterface

`default_nettype wire

// File: rtl/uvmt_cv32e40x_exception_sequencer.sv
// ============================================================================
// Module   : uvmt_cv32e40x_exception_sequencer
// Brief    : Carries exception candidates ID->EX->WB, resolves the cause at WB
//            by RISC-V priority, checks it against the DUT and counts traps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uvmt_cv32e40x_exception_sequencer #(
  parameter int CAUSE_W = 11,
  parameter int COUNT_W = 16
) (
  input  wire logic                          clk_i,
  input  wire logic                          rst_i,
  uvmt_cv32e40x_exception_sequencer_if.slave eif
);

  localparam logic [CAUSE_W-1:0] C_CAUSE_PMA    = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] C_CAUSE_IBUS   = CAUSE_W'(24);
  localparam logic [CAUSE_W-1:0] C_CAUSE_ILL    = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] C_CAUSE_EBREAK = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] C_CAUSE_ECALL  = CAUSE_W'(11);
  localparam logic [CAUSE_W-1:0] C_CAUSE_LD     = CAUSE_W'(4);
  localparam logic [CAUSE_W-1:0] C_CAUSE_ST     = CAUSE_W'(6);

  // Flag vector layout: {st, ld, ecall, ebreak, ill, ibus, pma}
  logic               r_id_valid, r_ex_valid, r_wb_valid;
  logic [6:0]         r_id_flags, r_ex_flags, r_wb_flags;
  logic               r_mismatch;
  logic [COUNT_W-1:0] r_count;

  logic [6:0]         w_ex_in_flags;
  logic [6:0]         w_wb_in_flags;
  logic               w_exc_valid;
  logic [CAUSE_W-1:0] w_cause_raw;
  logic [CAUSE_W-1:0] w_exc_cause;
  logic               w_check;
  logic               w_mismatch;

  // Flags from an empty stage are dropped so WB never reports a phantom trap
  assign w_ex_in_flags = (r_id_flags | {2'b00, eif.id_ecall_i, eif.id_ebreak_i,
                                        eif.id_illegal_i, 2'b00}) & {7{r_id_valid}};
  assign w_wb_in_flags = (r_ex_flags | {eif.ex_st_misalign_i, eif.ex_ld_misalign_i,
                                        5'b00000}) & {7{r_ex_valid}};

  always_comb begin
    w_cause_raw = '0;
    if      (r_wb_flags[0]) w_cause_raw = C_CAUSE_PMA;
    else if (r_wb_flags[1]) w_cause_raw = C_CAUSE_IBUS;
    else if (r_wb_flags[2]) w_cause_raw = C_CAUSE_ILL;
    else if (r_wb_flags[3]) w_cause_raw = C_CAUSE_EBREAK;
    else if (r_wb_flags[4]) w_cause_raw = C_CAUSE_ECALL;
    else if (r_wb_flags[5]) w_cause_raw = C_CAUSE_LD;
    else if (r_wb_flags[6]) w_cause_raw = C_CAUSE_ST;
  end

  assign w_exc_valid = r_wb_valid & (|r_wb_flags);
  assign w_exc_cause = w_exc_valid ? w_cause_raw : '0;
  assign w_check     = eif.wb_retire_i & r_wb_valid;
  assign w_mismatch  = w_check &
                       ((eif.dut_exc_valid_i != w_exc_valid) |
                        (eif.dut_exc_valid_i & w_exc_valid &
                         (eif.dut_exc_cause_i != w_exc_cause)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_valid <= 1'b0;
      r_id_flags <= '0;
      r_ex_valid <= 1'b0;
      r_ex_flags <= '0;
      r_wb_valid <= 1'b0;
      r_wb_flags <= '0;
      r_mismatch <= 1'b0;
      r_count    <= '0;
    end else begin
      // Flush overrides any fill of ID/EX; WB still accepts the old EX content
      if (eif.flush_i) begin
        r_id_valid <= 1'b0;
        r_id_flags <= '0;
      end else if (eif.ifid_hs_i) begin
        r_id_valid <= 1'b1;
        r_id_flags <= {5'b00000, eif.if_buserr_i, eif.if_pma_fault_i};
      end else if (eif.idex_hs_i) begin
        r_id_valid <= 1'b0;
        r_id_flags <= '0;
      end

      if (eif.flush_i) begin
        r_ex_valid <= 1'b0;
        r_ex_flags <= '0;
      end else if (eif.idex_hs_i) begin
        r_ex_valid <= r_id_valid;
        r_ex_flags <= w_ex_in_flags;
      end else if (eif.exwb_hs_i) begin
        r_ex_valid <= 1'b0;
        r_ex_flags <= '0;
      end

      if (eif.exwb_hs_i) begin
        r_wb_valid <= r_ex_valid;
        r_wb_flags <= w_wb_in_flags;
      end else if (eif.wb_retire_i) begin
        r_wb_valid <= 1'b0;
        r_wb_flags <= '0;
      end

      r_mismatch <= w_mismatch;

      if (eif.wb_retire_i && w_exc_valid && !(&r_count)) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign eif.exc_valid_o = w_exc_valid;
  assign eif.exc_cause_o = w_exc_cause;
  assign eif.exc_flags_o = r_wb_flags;
  assign eif.mismatch_o  = r_mismatch;
  assign eif.exc_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uvmt_cv32e40x_exception_sequencer.sv
// ============================================================================
// Module   : tb_uvmt_cv32e40x_exception_sequencer
// Brief    : Directed and randomized checks of the exception sequencer against
//            an instruction-record reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uvmt_cv32e40x_exception_sequencer;

  localparam int CAUSE_W = 11;
  localparam int COUNT_W = 2;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  uvmt_cv32e40x_exception_sequencer_if #(.CAUSE_W(CAUSE_W), .COUNT_W(COUNT_W)) eif();

  uvmt_cv32e40x_exception_sequencer #(.CAUSE_W(CAUSE_W), .COUNT_W(COUNT_W)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .eif   (eif)
  );

  // One in-flight instruction and the exception candidates it has collected
  typedef struct {
    bit live;
    bit pma, ibus, ill, ebk, ecall, ld, st;
  } instr_t;

  instr_t m_id, m_ex, m_wb;
  bit     m_mm;
  int     m_cnt;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t empty_instr();
    instr_t r;
    r = '{live: 1'b0, default: 1'b0};
    return r;
  endfunction

  function automatic logic [31:0] flag_word(input instr_t r);
    return {25'd0, r.st, r.ld, r.ecall, r.ebk, r.ill, r.ibus, r.pma};
  endfunction

  // Walk the priority list and return the first matching cause, 0 if none
  function automatic int cause_of(input instr_t r);
    int codes [7] = '{1, 24, 2, 3, 11, 4, 6};
    logic [31:0] v;
    v = flag_word(r);
    if (!r.live) return 0;
    for (int i = 0; i < 7; i++) if (v[i]) return codes[i];
    return 0;
  endfunction

  task automatic model_reset();
    m_id = empty_instr(); m_ex = empty_instr(); m_wb = empty_instr();
    m_mm = 1'b0; m_cnt = 0;
  endtask

  task automatic idle();
    eif.ifid_hs_i = 0; eif.idex_hs_i = 0; eif.exwb_hs_i = 0; eif.wb_retire_i = 0;
    eif.flush_i = 0; eif.if_pma_fault_i = 0; eif.if_buserr_i = 0;
    eif.id_illegal_i = 0; eif.id_ebreak_i = 0; eif.id_ecall_i = 0;
    eif.ex_ld_misalign_i = 0; eif.ex_st_misalign_i = 0;
    eif.dut_exc_valid_i = 0; eif.dut_exc_cause_i = '0;
  endtask

  task automatic compare_all(input string tag);
    int ec;
    ec = cause_of(m_wb);
    check({tag, "_valid"}, 32'(eif.exc_valid_o), 32'(ec != 0));
    check({tag, "_cause"}, 32'(eif.exc_cause_o), ec);
    check({tag, "_flags"}, 32'(eif.exc_flags_o), m_wb.live ? flag_word(m_wb) : 32'd0);
    check({tag, "_mismatch"}, 32'(eif.mismatch_o), 32'(m_mm));
    check({tag, "_count"}, 32'(eif.exc_count_o), m_cnt);
  endtask

  // Predict the clock edge from the current inputs, take it, then compare
  task automatic step(input string tag);
    instr_t nid, nex, nwb, t;
    bit     nmm;
    int     ncnt, ec;
    ec  = cause_of(m_wb);
    nmm = 1'b0;
    if (eif.wb_retire_i && m_wb.live) begin
      if (eif.dut_exc_valid_i != (ec != 0)) nmm = 1'b1;
      else if (ec != 0 && int'(eif.dut_exc_cause_i) != ec) nmm = 1'b1;
    end
    ncnt = m_cnt;
    if (eif.wb_retire_i && ec != 0 && m_cnt < CNT_MAX) ncnt = m_cnt + 1;

    nwb = m_wb;
    if (eif.exwb_hs_i) begin
      t = m_ex;
      t.ld = t.ld | eif.ex_ld_misalign_i;
      t.st = t.st | eif.ex_st_misalign_i;
      nwb = t.live ? t : empty_instr();
    end else if (eif.wb_retire_i) nwb = empty_instr();

    nex = m_ex;
    if (eif.flush_i) nex = empty_instr();
    else if (eif.idex_hs_i) begin
      t = m_id;
      t.ill   = t.ill   | eif.id_illegal_i;
      t.ebk   = t.ebk   | eif.id_ebreak_i;
      t.ecall = t.ecall | eif.id_ecall_i;
      nex = t.live ? t : empty_instr();
    end else if (eif.exwb_hs_i) nex = empty_instr();

    nid = m_id;
    if (eif.flush_i) nid = empty_instr();
    else if (eif.ifid_hs_i) begin
      nid = empty_instr();
      nid.live = 1'b1;
      nid.pma  = eif.if_pma_fault_i;
      nid.ibus = eif.if_buserr_i;
    end else if (eif.idex_hs_i) nid = empty_instr();

    @(posedge clk_i); #1;
    m_id = nid; m_ex = nex; m_wb = nwb; m_mm = nmm; m_cnt = ncnt;
    compare_all(tag);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  // Push one instruction fully to WB with the given per-stage flags
  task automatic send(input bit pma, input bit ibus, input bit ill, input bit ebk,
                      input bit ecall, input bit ld, input bit st);
    idle(); eif.ifid_hs_i = 1; eif.if_pma_fault_i = pma; eif.if_buserr_i = ibus; step("if");
    idle(); eif.idex_hs_i = 1; eif.id_illegal_i = ill; eif.id_ebreak_i = ebk;
    eif.id_ecall_i = ecall; step("id");
    idle(); eif.exwb_hs_i = 1; eif.ex_ld_misalign_i = ld; eif.ex_st_misalign_i = st; step("ex");
  endtask

  task automatic retire(input bit dv, input int dc, input string tag);
    idle(); eif.wb_retire_i = 1; eif.dut_exc_valid_i = dv; eif.dut_exc_cause_i = CAUSE_W'(dc);
    step(tag);
  endtask

  initial begin
    idle();
    model_reset();
    do_reset();
    check("t1_count0", 32'(eif.exc_count_o), 32'd0);

    send(0, 1, 1, 0, 0, 0, 0);
    check("t2_flags", 32'(eif.exc_flags_o), 32'h06);
    check("t2_cause", 32'(eif.exc_cause_o), 32'd24);
    retire(1, 24, "t2_ret");
    check("t2_count", 32'(eif.exc_count_o), 32'd1);
    check("t2_nomm", 32'(eif.mismatch_o), 32'd0);

    send(0, 0, 0, 0, 1, 1, 0);
    check("t3_cause", 32'(eif.exc_cause_o), 32'd11);
    retire(1, 4, "t3_ret");
    check("t3_mm_on", 32'(eif.mismatch_o), 32'd1);
    idle(); step("t3_after");
    check("t3_mm_off", 32'(eif.mismatch_o), 32'd0);

    do_reset();
    idle(); eif.ifid_hs_i = 1; step("t4_if");
    idle(); eif.idex_hs_i = 1; step("t4_id");
    idle(); eif.flush_i = 1; eif.ifid_hs_i = 1; eif.if_pma_fault_i = 1; eif.exwb_hs_i = 1;
    step("t4_flush");
    check("t4_wbexc", 32'(eif.exc_valid_o), 32'd0);
    retire(0, 0, "t4_ret");
    check("t4_nomm", 32'(eif.mismatch_o), 32'd0);
    idle(); eif.idex_hs_i = 1; step("t4_id2");
    idle(); eif.exwb_hs_i = 1; step("t4_ex2");
    check("t4_wbempty", 32'(eif.exc_flags_o), 32'd0);

    do_reset();
    for (int n = 0; n < 5; n++) begin
      send(0, 0, 0, 1, 0, 0, 0);
      retire(1, 3, "t5_ret");
      check("t5_nomm", 32'(eif.mismatch_o), 32'd0);
    end
    check("t5_sat", 32'(eif.exc_count_o), 32'd3);
    idle(); step("t5_hold");
    check("t5_sat_hold", 32'(eif.exc_count_o), 32'd3);

    idle(); eif.ifid_hs_i = 1; eif.if_pma_fault_i = 1; step("t6_a");
    idle(); eif.ifid_hs_i = 1; eif.if_buserr_i = 1; eif.idex_hs_i = 1; eif.id_illegal_i = 1;
    step("t6_b");
    idle(); eif.ifid_hs_i = 1; eif.if_pma_fault_i = 1; eif.idex_hs_i = 1; eif.id_ecall_i = 1;
    eif.exwb_hs_i = 1; eif.ex_st_misalign_i = 1; step("t6_c");
    check("t6_pre_valid", 32'(eif.exc_valid_o), 32'd1);
    idle();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check("t6_rst_valid", 32'(eif.exc_valid_o), 32'd0);
    check("t6_rst_cause", 32'(eif.exc_cause_o), 32'd0);
    check("t6_rst_flags", 32'(eif.exc_flags_o), 32'd0);
    check("t6_rst_count", 32'(eif.exc_count_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    retire(1, 1, "t6_ret");
    check("t6_nomm", 32'(eif.mismatch_o), 32'd0);
    idle(); step("t6_after");

    // Random traffic, DUT cause mostly agrees with the model
    for (int c = 0; c < 600; c++) begin
      int ec;
      ec = cause_of(m_wb);
      eif.ifid_hs_i        = ($urandom_range(0, 1) == 1);
      eif.idex_hs_i        = ($urandom_range(0, 1) == 1);
      eif.exwb_hs_i        = ($urandom_range(0, 1) == 1);
      eif.wb_retire_i      = ($urandom_range(0, 1) == 1);
      eif.flush_i          = ($urandom_range(0, 9) == 0);
      eif.if_pma_fault_i   = ($urandom_range(0, 7) == 0);
      eif.if_buserr_i      = ($urandom_range(0, 7) == 0);
      eif.id_illegal_i     = ($urandom_range(0, 7) == 0);
      eif.id_ebreak_i      = ($urandom_range(0, 7) == 0);
      eif.id_ecall_i       = ($urandom_range(0, 7) == 0);
      eif.ex_ld_misalign_i = ($urandom_range(0, 7) == 0);
      eif.ex_st_misalign_i = ($urandom_range(0, 7) == 0);
      eif.dut_exc_valid_i  = (ec != 0);
      eif.dut_exc_cause_i  = CAUSE_W'(ec);
      if ($urandom_range(0, 9) == 0) eif.dut_exc_valid_i = ~eif.dut_exc_valid_i;
      if ($urandom_range(0, 9) == 0) eif.dut_exc_cause_i = CAUSE_W'($urandom_range(0, 31));
      step("rnd");
      if (c % 150 == 149) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
